// File: rtl/alu_pkg.sv
// alu_pkg: shared mode/state encodings and default sizing for the ALU operand bank
package alu_pkg;
   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SEQ    = 2'b01,
      MODE_BCAST  = 2'b10,
      MODE_NOP    = 2'b11
   } mode_t;
   typedef enum logic {ST_FILL = 1'b0, ST_PRESENT = 1'b1} state_t;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_NUM_CH = 4;
endpackage

// File: rtl/alu_operand_bank_if.sv
// alu_operand_bank_if: producer write bus and ALU-side handshake of the operand bank
interface alu_operand_bank_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = $clog2(NUM_CH)
);
   logic                     enable;
   logic [1:0]               mode;
   logic [SEL_W-1:0]         select;
   logic [DATA_W-1:0]        data_in;
   logic                     clear;
   logic                     in_ready;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] data_out;
   logic                     out_valid;
   logic                     out_ready;
   logic [SEL_W-1:0]         load_ptr;
   modport master (
      output enable, mode, select, data_in, clear, out_ready,
      input  in_ready, ch_valid, data_out, out_valid, load_ptr
   );
   modport slave (
      input  enable, mode, select, data_in, clear, out_ready,
      output in_ready, ch_valid, data_out, out_valid, load_ptr
   );
endinterface

// File: rtl/alu_operand_reg.sv
// alu_operand_reg: one operand channel register with a loaded flag
module alu_operand_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              clr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              valid
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q     <= '0;
         valid <= 1'b0;
      end else begin
         if (we) q <= d;
         valid <= !clr && (we || valid);
      end
endmodule

// File: rtl/alu_operand_bank.sv
// alu_operand_bank: captures a shared bus into NUM_CH operand channels and presents the full set to the ALU
module alu_operand_bank
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input logic               clk,
   input logic               rst,
   alu_operand_bank_if.slave bus
);
   state_t                   state, state_nx;
   logic [SEL_W-1:0]         ptr;
   logic [NUM_CH-1:0]        we, valid;
   logic [NUM_CH*DATA_W-1:0] data;
   logic                     wr, flush;
   assign wr    = bus.enable && state == ST_FILL && bus.mode != MODE_NOP && !bus.clear;
   assign flush = bus.clear || (state == ST_PRESENT && bus.out_ready);
   always_comb
      state_nx = bus.clear ? ST_FILL :
                 state == ST_FILL ? (&valid ? ST_PRESENT : ST_FILL) :
                 bus.out_ready ? ST_FILL : ST_PRESENT;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ST_FILL;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         if (flush) ptr <= '0;
         else if (wr && bus.mode == MODE_SEQ) ptr <= ptr == SEL_W'(NUM_CH - 1) ? '0 : ptr + SEL_W'(1);
      end
   // an out-of-range direct select matches no channel, so the write is dropped
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign we[k] = wr && (bus.mode == MODE_BCAST ||
                            (bus.mode == MODE_DIRECT && bus.select == SEL_W'(k)) ||
                            (bus.mode == MODE_SEQ && ptr == SEL_W'(k)));
      alu_operand_reg #(.DATA_W(DATA_W)) u_reg (
         .clk   (clk),
         .rst   (rst),
         .we    (we[k]),
         .clr   (flush),
         .d     (bus.data_in),
         .q     (data[k*DATA_W +: DATA_W]),
         .valid (valid[k])
      );
   end
   assign bus.in_ready  = state == ST_FILL;
   assign bus.out_valid = state == ST_PRESENT;
   assign bus.ch_valid  = valid;
   assign bus.data_out  = data;
   assign bus.load_ptr  = ptr;
endmodule

// File: tb/tb_alu_operand_bank.sv
// tb_alu_operand_bank: directed and random checks of two operand bank sizes against a behavioural model
module tb_alu_operand_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_operand_bank_if #(.DATA_W(16), .NUM_CH(4)) ifa ();
   alu_operand_bank_if #(.DATA_W(8),  .NUM_CH(3)) ifb ();
   alu_operand_bank #(.DATA_W(16), .NUM_CH(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   alu_operand_bank #(.DATA_W(8),  .NUM_CH(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int vectors = 0, miscompares = 0;
   int hs_b = 0;
   always @(posedge clk) if (ifb.out_valid && ifb.out_ready) hs_b <= hs_b + 1;

   // reference model state, index 0 = 4x16 bank, 1 = 3x8 bank
   int        n_ch[2]   = '{4, 3};
   int        w_bits[2] = '{16, 8};
   int        m_data[2][16];
   bit [15:0] m_valid[2];
   int        m_ptr[2];
   bit        m_pres[2];
   bit        i_en[2], i_clr[2], i_ordy[2];
   int        i_mode[2], i_sel[2], i_din[2];

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) m_data[d][k] = 0;
         m_valid[d] = '0;
         m_ptr[d]   = 0;
         m_pres[d]  = 1'b0;
      end
   endfunction

   function automatic void model_tick(int d);
      int        n    = n_ch[d];
      bit [15:0] full = 16'((1 << n) - 1);
      bit        wr   = i_en[d] && !m_pres[d] && i_mode[d] != 3 && !i_clr[d];
      if (i_clr[d]) begin
         m_valid[d] = '0; m_ptr[d] = 0; m_pres[d] = 1'b0;
      end else if (m_pres[d]) begin
         if (i_ordy[d]) begin m_valid[d] = '0; m_ptr[d] = 0; m_pres[d] = 1'b0; end
      end else begin
         if (m_valid[d] == full) m_pres[d] = 1'b1;
         if (wr) begin
            if (i_mode[d] == 0 && i_sel[d] < n) begin
               m_data[d][i_sel[d]] = i_din[d]; m_valid[d][i_sel[d]] = 1'b1;
            end else if (i_mode[d] == 1) begin
               m_data[d][m_ptr[d]] = i_din[d]; m_valid[d][m_ptr[d]] = 1'b1;
               m_ptr[d] = (m_ptr[d] + 1) % n;
            end else if (i_mode[d] == 2) begin
               for (int k = 0; k < n; k++) m_data[d][k] = i_din[d];
               m_valid[d] = full;
            end
         end
      end
   endfunction

   task automatic cmp(string tag, int d, logic [255:0] obs, logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[bank%0d]: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   task automatic check(int d);
      logic [255:0] ev = '0;
      for (int k = 0; k < n_ch[d]; k++) ev = ev | (256'(m_data[d][k]) << (k * w_bits[d]));
      cmp("data_out",  d, d ? 256'(ifb.data_out)  : 256'(ifa.data_out),  ev);
      cmp("ch_valid",  d, d ? 256'(ifb.ch_valid)  : 256'(ifa.ch_valid),  256'(m_valid[d]));
      cmp("load_ptr",  d, d ? 256'(ifb.load_ptr)  : 256'(ifa.load_ptr),  256'(m_ptr[d]));
      cmp("in_ready",  d, d ? 256'(ifb.in_ready)  : 256'(ifa.in_ready),  256'(!m_pres[d]));
      cmp("out_valid", d, d ? 256'(ifb.out_valid) : 256'(ifa.out_valid), 256'(m_pres[d]));
   endtask

   task automatic set_in(int d, bit en, int mode, int sel, int din, bit clr, bit ordy);
      i_en[d] = en; i_mode[d] = mode; i_sel[d] = sel; i_clr[d] = clr; i_ordy[d] = ordy;
      i_din[d] = din & ((1 << w_bits[d]) - 1);
      if (d == 0) begin
         ifa.enable = en; ifa.mode = 2'(mode); ifa.select = 2'(sel);
         ifa.data_in = 16'(din); ifa.clear = clr; ifa.out_ready = ordy;
      end else begin
         ifb.enable = en; ifb.mode = 2'(mode); ifb.select = 2'(sel);
         ifb.data_in = 8'(din); ifb.clear = clr; ifb.out_ready = ordy;
      end
   endtask

   task automatic idle(int d);
      set_in(d, 1'b0, 3, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick(0);
      model_tick(1);
      #1;
      check(0);
      check(1);
   endtask

   int vals[4] = '{'h3333, 'h1111, 'h2222, 'h4444};
   int hs_snap;

   initial begin
      idle(0); idle(1);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check(0); check(1);
      rst = 1'b0;
      // direct fill
      for (int i = 0; i < 4; i++) begin set_in(0, 1'b1, 0, i, vals[i], 1'b0, 1'b0); tick(); end
      idle(0); tick();
      cmp("direct_set", 0, 256'(ifa.data_out), 256'(64'h4444_2222_1111_3333));
      set_in(0, 1'b0, 3, 0, 0, 1'b0, 1'b1); tick();
      // sequential fill, write in PRESENT is dropped, then handshake with a lost write
      for (int i = 1; i <= 4; i++) begin set_in(0, 1'b1, 1, 0, i, 1'b0, 1'b0); tick(); end
      cmp("seq_wrap", 0, 256'(ifa.load_ptr), 256'(0));
      idle(0); tick();
      set_in(0, 1'b1, 1, 0, 5, 1'b0, 1'b0); tick();
      set_in(0, 1'b1, 1, 0, 6, 1'b0, 1'b1); tick();
      cmp("seq_keep", 0, 256'(ifa.data_out), 256'(64'h0004_0003_0002_0001));
      // broadcast
      set_in(0, 1'b1, 2, 0, 'hABCD, 1'b0, 1'b0); tick();
      idle(0); tick();
      cmp("bcast", 0, 256'(ifa.data_out), 256'(64'hABCD_ABCD_ABCD_ABCD));
      set_in(0, 1'b0, 3, 0, 0, 1'b0, 1'b1); tick();
      // partial fill then clear racing a write
      set_in(0, 1'b1, 0, 0, 'h11, 1'b0, 1'b0); tick();
      set_in(0, 1'b1, 0, 1, 'h22, 1'b0, 1'b0); tick();
      set_in(0, 1'b1, 0, 2, 'h99, 1'b1, 1'b0); tick();
      cmp("clear_ch2", 0, 256'(ifa.data_out[47:32]), 256'(16'hABCD));
      // asynchronous reset mid-fill
      set_in(0, 1'b1, 0, 3, 'h55, 1'b0, 1'b0); tick();
      idle(0);
      rst = 1'b1;
      #1;
      model_reset();
      check(0); check(1);
      cmp("async_rst", 0, 256'(ifa.data_out), 256'(0));
      @(negedge clk) rst = 1'b0;
      // small bank: out-of-range select, pointer wrap, repeated handshakes
      set_in(1, 1'b1, 0, 3, 'h77, 1'b0, 1'b0); tick();
      cmp("sel_oob", 1, 256'(ifb.ch_valid), 256'(0));
      for (int i = 1; i <= 3; i++) begin set_in(1, 1'b1, 1, 0, 'h10 + i, 1'b0, 1'b0); tick(); end
      cmp("ptr_wrap", 1, 256'(ifb.load_ptr), 256'(0));
      idle(1); tick();
      set_in(1, 1'b0, 3, 0, 0, 1'b0, 1'b1); tick();
      hs_snap = hs_b;
      for (int i = 1; i <= 10; i++) begin
         set_in(1, 1'b1, 2, 0, i, 1'b0, 1'b0); tick();
         idle(1); tick();
         cmp("hs_set", 1, 256'(ifb.data_out), 256'({3{8'(i)}}));
         set_in(1, 1'b0, 3, 0, 0, 1'b0, 1'b1); tick();
      end
      cmp("hs_count", 1, 256'(hs_b - hs_snap), 256'(10));
      // random traffic on both banks
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++)
            set_in(d, 1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
                   int'($urandom), $urandom_range(15) == 0, $urandom_range(2) == 0);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_operand_bank.md
Name: alu_operand_bank

Overview:
Parametrised successor to the 4-way ALU operand mux. It captures a shared data bus into NUM_CH registered operand channels and supports three load modes: direct select, auto-increment sequential, and broadcast. Once every channel is loaded, it presents the whole operand set to the downstream ALU through a valid/ready handshake. It sits between the core's register-file read path and the ALU datapath in each of the 8 cores.

Parameters:
DATA_W, 16, width of each operand channel and of data_in
NUM_CH, 4, number of operand channels (2..16)
SEL_W, $clog2(NUM_CH), width of select and of the internal load pointer

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  write request; a write is accepted when enable && in_ready
mode  in  2  00 direct, 01 sequential auto-increment, 10 broadcast, 11 no write
select  in  SEL_W  target channel in direct mode; ignored in other modes
data_in  in  DATA_W  write data
clear  in  1  synchronous flush of valid bits, pointer and state
in_ready  out  1  bank accepts writes (state FILL)
ch_valid  out  NUM_CH  per-channel loaded flag
data_out  out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
out_valid  out  1  full operand set presented (state PRESENT)
out_ready  in  1  ALU consumes the operand set
load_ptr  out  SEL_W  current sequential pointer (debug and verification)

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: data_out all 0, ch_valid 0, load_ptr 0, state FILL, in_ready 1, out_valid 0.
- The state machine has two states, FILL and PRESENT. in_ready = (state==FILL). out_valid = (state==PRESENT).
- Accepted write = enable && in_ready && mode!=11 && !clear. Register data and ch_valid update on the edge, so there is 1-cycle latency to data_out and ch_valid.
- Direct mode (00): write channel select and set its valid bit. If select >= NUM_CH (non-power-of-2 NUM_CH), drop the write with no state change.
- Sequential mode (01): write channel load_ptr and set its valid bit. load_ptr increments and wraps from NUM_CH-1 to 0. load_ptr changes only on accepted sequential writes.
- Broadcast mode (10): write data_in to all channels and set all valid bits in one cycle.
- Rewriting an already-valid channel in FILL overwrites the data; its valid bit stays 1.
- FILL -> PRESENT on the edge after ch_valid becomes all-ones. out_valid therefore rises one cycle after the last valid bit sets (2 cycles after the final write).
- PRESENT: data_out is frozen and writes are ignored, since in_ready=0.
- PRESENT -> FILL when out_valid && out_ready. On that edge ch_valid clears to 0 and load_ptr clears to 0. data_out retains its values.
- out_ready while in FILL has no effect.
- clear has priority over writes and the handshake. It sets ch_valid=0, load_ptr=0 and state FILL on the next edge, and leaves data_out unchanged.
- Asserting rst mid-fill or mid-present returns everything to reset values immediately, without waiting for a clock edge.
- Simultaneous handshake and enable in PRESENT: the write is lost, because in_ready was 0 in that cycle. The producer must hold the write until in_ready=1.

Decomposition:
- Shared package alu_pkg holds:
  - mode encodings MODE_DIRECT=2'b00, MODE_SEQ=2'b01, MODE_BCAST=2'b10, MODE_NOP=2'b11;
  - the state encoding ST_FILL and ST_PRESENT;
  - the default DATA_W=16 and NUM_CH=4.
- Natural sub-module: alu_operand_reg, one DATA_W register with async reset, write enable and a valid flag. It is instantiated NUM_CH times in a generate loop. The FSM and pointer stay in the top level.

Test Plan:
- Reset with rst=1 for 3 cycles, then release -> data_out=0, ch_valid=0000, in_ready=1, out_valid=0. Assert rst mid-fill -> all outputs return to 0 without a clock edge.
- Direct mode, 4 writes: select 0..3 with 16'h3333, 16'h1111, 16'h2222, 16'h4444 -> ch_valid 0001, 0011, 0111, 1111. out_valid=1 on the following cycle, with data_out={4444,2222,1111,3333}.
- Sequential mode, 5 writes at NUM_CH=4: write 1, 2, 3, 4, with out_ready=0. The 4th write fills the bank and load_ptr wraps to 0. The 5th write (value 5) is ignored because in_ready=0. Pulse out_ready -> ch_valid=0000, load_ptr=0, data_out still {4,3,2,1}.
- Broadcast of 16'hABCD -> all channels = ABCD, ch_valid=1111, out_valid=1 the next cycle.
- Partial fill then clear: fill channels 0 and 1, assert clear together with enable on channel 2 -> ch_valid=0000, channel 2 data unchanged, state FILL.
- Parameter sweep with NUM_CH=3, DATA_W=8: direct write with select=3 is ignored. Sequential pointer wraps 2 -> 0. Handshake cycle repeated 10 times back-to-back with no lost or duplicated sets.
